// File: rtl/tag_memory_nway_pkg.sv
// Shared widths, FSM encodings and helpers for the N-way tag store and its cache controller.
package tag_memory_nway_pkg;

    localparam int BW_WORD_ADDR = 32;
    localparam int BW_BLOCK     = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

    function automatic int clog2(input int value);
        return $clog2(value);
    endfunction

    function automatic int bw_cache_addr(input int capacity);
        return clog2(capacity);
    endfunction

    function automatic int bw_grp(input int capacity, input int n_ways);
        return clog2(capacity) - clog2(n_ways);
    endfunction

    function automatic int bw_tag(input int capacity, input int n_ways);
        return BW_WORD_ADDR - bw_grp(capacity, n_ways) - BW_BLOCK;
    endfunction

endpackage

// File: rtl/tag_memory_nway_plru_tree.sv
// Tree pseudo-LRU for one set: walks the heap-indexed bits to a victim and
// computes the bits after an access that points every node on the path away from it.
module plru_tree
    import tag_memory_nway_pkg::*;
#(
    parameter  int N_WAYS = 4,
    localparam int BW_WAY = clog2(N_WAYS)
) (
    input  logic [N_WAYS-1:1] bits_i,
    input  logic [BW_WAY-1:0] way_i,
    output logic [BW_WAY-1:0] victim_o,
    output logic [N_WAYS-1:1] bits_o
);

    logic [BW_WAY-1:0] walk_node;
    logic [BW_WAY-1:0] upd_node;

    always_comb begin
        walk_node = BW_WAY'(1);
        victim_o  = '0;
        for (int l = 0; l < BW_WAY; l++) begin
            victim_o[BW_WAY-1-l] = bits_i[walk_node];
            walk_node = (walk_node << 1) | BW_WAY'(bits_i[walk_node]);
        end
    end

    // A 0 bit steers the victim to the lower half, so an upper-half access stores 0.
    always_comb begin
        upd_node = BW_WAY'(1);
        bits_o   = bits_i;
        for (int l = 0; l < BW_WAY; l++) begin
            bits_o[upd_node] = ~way_i[BW_WAY-1-l];
            upd_node = (upd_node << 1) | BW_WAY'(way_i[BW_WAY-1-l]);
        end
    end

endmodule

// File: rtl/tag_memory_nway.sv
// N-way set-associative tag store: combinational lookup/readback, PLRU victim
// nomination, dirty tracking and a one-set-per-cycle flush sweep.
module tag_memory_nway
    import tag_memory_nway_pkg::*;
#(
    parameter  int CACHE_BLOCK_CAPACITY = 128,
    parameter  int N_WAYS               = 4,
    localparam int BW_CACHE_ADDR        = bw_cache_addr(CACHE_BLOCK_CAPACITY),
    localparam int BW_WAY               = clog2(N_WAYS),
    localparam int BW_GRP               = BW_CACHE_ADDR - BW_WAY,
    localparam int BW_TAG               = bw_tag(CACHE_BLOCK_CAPACITY, N_WAYS)
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     wren_i,
    input  logic                     rmen_i,
    input  logic                     touch_i,
    input  logic                     dirty_i,
    input  logic                     flush_i,
    input  logic [BW_TAG-1:0]        tag_i,
    input  logic [BW_GRP-1:0]        group_i,
    input  logic [BW_CACHE_ADDR-1:0] addr_i,
    output logic [BW_CACHE_ADDR-1:0] addr_o,
    output logic                     hit_o,
    output logic [BW_TAG-1:0]        tag_o,
    output logic                     dirty_o,
    output logic                     busy_o
);

    localparam int N_SETS = 1 << BW_GRP;

    flush_state_e      state_q, state_d;
    logic [BW_GRP-1:0] cnt_q, cnt_d;

    logic [BW_TAG-1:0] tags_q  [N_WAYS][N_SETS];
    logic [BW_TAG-1:0] tags_d  [N_WAYS][N_SETS];
    logic              valid_q [N_WAYS][N_SETS];
    logic              valid_d [N_WAYS][N_SETS];
    logic              dirty_q [N_WAYS][N_SETS];
    logic              dirty_d [N_WAYS][N_SETS];
    logic [N_WAYS-1:1] plru_q  [N_SETS];
    logic [N_WAYS-1:1] plru_d  [N_SETS];

    logic [BW_WAY-1:0] acc_way;
    logic [BW_GRP-1:0] acc_grp;

    logic              hit_any;
    logic [BW_WAY-1:0] hit_way;
    logic              inv_any;
    logic [BW_WAY-1:0] inv_way;
    logic [BW_WAY-1:0] plru_victim;
    logic [N_WAYS-1:1] plru_next;
    logic [N_WAYS-1:1] unused_lookup_bits;
    logic [BW_WAY-1:0] unused_update_victim;

    assign acc_way = addr_i[BW_CACHE_ADDR-1 -: BW_WAY];
    assign acc_grp = addr_i[BW_GRP-1:0];

    plru_tree #(.N_WAYS(N_WAYS)) u_plru_lookup (
        .bits_i   (plru_q[group_i]),
        .way_i    ('0),
        .victim_o (plru_victim),
        .bits_o   (unused_lookup_bits)
    );

    plru_tree #(.N_WAYS(N_WAYS)) u_plru_update (
        .bits_i   (plru_q[acc_grp]),
        .way_i    (acc_way),
        .victim_o (unused_update_victim),
        .bits_o   (plru_next)
    );

    // Descending scan so the lowest matching / lowest invalid way is the one kept.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][group_i] && (tags_q[w][group_i] == tag_i)) begin
                hit_any = 1'b1;
                hit_way = BW_WAY'(w);
            end
            if (!valid_q[w][group_i]) begin
                inv_any = 1'b1;
                inv_way = BW_WAY'(w);
            end
        end
    end

    always_comb begin
        busy_o  = (state_q == ST_FLUSH);
        hit_o   = hit_any & ~busy_o;
        if (hit_o) begin
            addr_o = {hit_way, group_i};
        end else if (inv_any) begin
            addr_o = {inv_way, group_i};
        end else begin
            addr_o = {plru_victim, group_i};
        end
        tag_o   = tags_q[acc_way][acc_grp];
        dirty_o = valid_q[acc_way][acc_grp] & dirty_q[acc_way][acc_grp];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tags_d  = tags_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        plru_d  = plru_q;
        if (state_q == ST_IDLE) begin
            if (wren_i) begin
                tags_d[acc_way][acc_grp]  = tag_i;
                valid_d[acc_way][acc_grp] = 1'b1;
                dirty_d[acc_way][acc_grp] = dirty_i;
            end
            if (touch_i && dirty_i) begin
                dirty_d[acc_way][acc_grp] = 1'b1;
            end
            // Remove is applied last so it wins over a same-edge write.
            if (rmen_i) begin
                valid_d[acc_way][acc_grp] = 1'b0;
                dirty_d[acc_way][acc_grp] = 1'b0;
            end
            if (wren_i || touch_i) begin
                plru_d[acc_grp] = plru_next;
            end
            if (flush_i) begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
        end else begin
            for (int w = 0; w < N_WAYS; w++) begin
                valid_d[w][cnt_q] = 1'b0;
                dirty_d[w][cnt_q] = 1'b0;
            end
            plru_d[cnt_q] = '0;
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == {BW_GRP{1'b1}}) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tags_q  <= '{default: '0};
            valid_q <= '{default: 1'b0};
            dirty_q <= '{default: 1'b0};
            plru_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tags_q  <= tags_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            plru_q  <= plru_d;
        end
    end

endmodule

// File: tb/tb_tag_memory_nway.sv
// Bench for tag_memory_nway with 16 blocks / 4 ways: per-cycle model comparison
// plus hand-computed literal expectations for the directed scenarios.
module tb_tag_memory_nway;

    localparam int CAP    = 16;
    localparam int NW     = 4;
    localparam int NS     = 4;
    localparam int BW_TAG = 32 - 2 - 4;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              wren_i = 1'b0;
    logic              rmen_i = 1'b0;
    logic              touch_i = 1'b0;
    logic              dirty_i = 1'b0;
    logic              flush_i = 1'b0;
    logic [BW_TAG-1:0] tag_i = '0;
    logic [1:0]        group_i = '0;
    logic [3:0]        addr_i = '0;
    logic [3:0]        addr_o;
    logic              hit_o;
    logic [BW_TAG-1:0] tag_o;
    logic              dirty_o;
    logic              busy_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    tag_memory_nway #(.CACHE_BLOCK_CAPACITY(CAP), .N_WAYS(NW)) dut (
        .clock_i (clk),
        .reset_i (reset_i),
        .wren_i  (wren_i),
        .rmen_i  (rmen_i),
        .touch_i (touch_i),
        .dirty_i (dirty_i),
        .flush_i (flush_i),
        .tag_i   (tag_i),
        .group_i (group_i),
        .addr_i  (addr_i),
        .addr_o  (addr_o),
        .hit_o   (hit_o),
        .tag_o   (tag_o),
        .dirty_o (dirty_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    // Reference state: tags/valid/dirty per (way, set), PLRU node bits per set.
    int m_tag   [NW][NS];
    bit m_valid [NW][NS];
    bit m_dirty [NW][NS];
    bit m_lru   [NS][NW];
    bit m_busy;
    int m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_victim(input int g);
        int n;
        n = 1;
        while (n < NW) n = 2 * n + int'(m_lru[g][n]);
        return n - NW;
    endfunction

    task automatic model_access(input int g, input int w);
        int node;
        int upper;
        for (int l = 0; l < 2; l++) begin
            node  = (NW + w) >> (2 - l);
            upper = ((NW + w) >> (1 - l)) & 1;
            m_lru[g][node] = (upper == 0);
        end
    endtask

    task automatic model_clear_set(input int g);
        for (int w = 0; w < NW; w++) begin
            m_valid[w][g] = 1'b0;
            m_dirty[w][g] = 1'b0;
        end
        for (int n = 0; n < NW; n++) m_lru[g][n] = 1'b0;
    endtask

    always @(posedge clk) begin
        int w;
        int g;
        w = int'(addr_i[3:2]);
        g = int'(addr_i[1:0]);
        if (reset_i) begin
            for (int s = 0; s < NS; s++) begin
                model_clear_set(s);
                for (int k = 0; k < NW; k++) m_tag[k][s] = 0;
            end
            m_busy = 1'b0;
            m_cnt  = 0;
        end else if (m_busy) begin
            model_clear_set(m_cnt);
            if (m_cnt == NS - 1) m_busy = 1'b0;
            m_cnt = (m_cnt + 1) % NS;
        end else begin
            if (wren_i) begin
                m_tag[w][g]   = int'(tag_i);
                m_valid[w][g] = 1'b1;
                m_dirty[w][g] = dirty_i;
            end
            if (touch_i && dirty_i) m_dirty[w][g] = 1'b1;
            if (rmen_i) begin
                m_valid[w][g] = 1'b0;
                m_dirty[w][g] = 1'b0;
            end
            if (wren_i || touch_i) model_access(g, w);
            if (flush_i) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        int hw;
        int iw;
        int exp_addr;
        bit exp_hit;
        if (chk_en) begin
            g  = int'(group_i);
            hw = -1;
            iw = -1;
            for (int w = NW - 1; w >= 0; w--) begin
                if (m_valid[w][g] && m_tag[w][g] == int'(tag_i)) hw = w;
                if (!m_valid[w][g]) iw = w;
            end
            exp_hit = (hw >= 0) && !m_busy;
            if (exp_hit)      exp_addr = hw * NS + g;
            else if (iw >= 0) exp_addr = iw * NS + g;
            else              exp_addr = model_victim(g) * NS + g;
            check("model_hit", 32'(hit_o), 32'(exp_hit));
            check("model_addr", 32'(addr_o), 32'(exp_addr));
            check("model_busy", 32'(busy_o), 32'(m_busy));
            check("model_tag", 32'(tag_o), 32'(m_tag[addr_i[3:2]][addr_i[1:0]]));
            check("model_dirty", 32'(dirty_o),
                  32'(m_valid[addr_i[3:2]][addr_i[1:0]] & m_dirty[addr_i[3:2]][addr_i[1:0]]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int a, input int t, input bit d);
        wren_i  = 1'b1;
        addr_i  = 4'(a);
        tag_i   = BW_TAG'(t);
        dirty_i = d;
        tick();
        wren_i  = 1'b0;
        dirty_i = 1'b0;
    endtask

    initial begin
        tick();
        chk_en  = 1'b1;
        tick();
        reset_i = 1'b0;
        group_i = 2'd2;
        addr_i  = 4'd7;
        #2;
        check("reset_hit", 32'(hit_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_tag", 32'(tag_o), 32'd0);
        check("reset_dirty", 32'(dirty_o), 32'd0);
        check("reset_addr", 32'(addr_o), 32'd2);

        for (int w = 0; w < NW; w++) write(w * 4 + 1, 'hA + w, 1'b0);
        tag_i = BW_TAG'('hC); group_i = 2'd1;
        #2;
        check("fill_hit", 32'(hit_o), 32'd1);
        check("fill_addr", 32'(addr_o), 32'd9);
        tag_i = BW_TAG'('h55);
        #2;
        check("plru_victim_way0", 32'(addr_o), 32'd1);

        touch_i = 1'b1; addr_i = 4'd1;
        tick();
        touch_i = 1'b0;
        #2;
        check("plru_victim_way2", 32'(addr_o), 32'd9);

        rmen_i = 1'b1; addr_i = 4'd13;
        tick();
        rmen_i = 1'b0;
        #2;
        check("invalid_pref", 32'(addr_o), 32'd13);

        wren_i = 1'b1; rmen_i = 1'b1; addr_i = 4'd5; tag_i = BW_TAG'('h77); dirty_i = 1'b1;
        tick();
        wren_i = 1'b0; rmen_i = 1'b0; dirty_i = 1'b0;
        #2;
        check("collision_hit", 32'(hit_o), 32'd0);
        check("collision_dirty", 32'(dirty_o), 32'd0);

        write(6, 'h33, 1'b1);
        addr_i = 4'd6;
        #2;
        check("dirty_before_flush", 32'(dirty_o), 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        wren_i = 1'b1; addr_i = 4'd2; tag_i = BW_TAG'('h44); dirty_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("flush_busy_high", 32'(busy_o), 32'd1);
            tick();
        end
        wren_i = 1'b0; dirty_i = 1'b0;
        #2;
        check("flush_busy_low", 32'(busy_o), 32'd0);
        tag_i = BW_TAG'('h44); group_i = 2'd2;
        #2;
        check("flush_write_dropped", 32'(hit_o), 32'd0);
        check("flush_victim_g2", 32'(addr_o), 32'd2);
        tag_i = BW_TAG'('hC); group_i = 2'd1;
        #2;
        check("flush_miss_g1", 32'(hit_o), 32'd0);
        check("flush_victim_g1", 32'(addr_o), 32'd1);
        addr_i = 4'd6;
        #2;
        check("flush_dirty_clear", 32'(dirty_o), 32'd0);
        check("flush_keeps_tag", 32'(tag_o), 32'h33);

        write(9, 'hC, 1'b0);
        write(15, 'h5A, 1'b1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        #2;
        check("midflush_busy", 32'(busy_o), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        tag_i = BW_TAG'('hC); group_i = 2'd1; addr_i = 4'd15;
        #2;
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_hit", 32'(hit_o), 32'd0);
        check("rst_mid_tag", 32'(tag_o), 32'd0);
        check("rst_mid_addr", 32'(addr_o), 32'd1);
        write(9, 'hC, 1'b0);
        #2;
        check("rst_idle_write_hit", 32'(hit_o), 32'd1);
        check("rst_idle_write_addr", 32'(addr_o), 32'd9);

        for (int i = 0; i < 24; i++) begin
            wren_i  = (i % 3 != 0);
            touch_i = (i % 3 == 0);
            rmen_i  = (i % 7 == 6);
            dirty_i = i[0];
            addr_i  = 4'((i * 5) % 16);
            tag_i   = BW_TAG'(i % 5);
            group_i = 2'((i * 3) % 4);
            tick();
        end
        wren_i = 1'b0; touch_i = 1'b0; rmen_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tag_i   = BW_TAG'(i % 5);
            group_i = 2'(i);
            addr_i  = 4'(i * 2);
            tick();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
